// File: rtl/ac_out_port.sv
// ac_out_port: buffers accumulator OUT writes in a small FIFO and streams them over valid/ready
module ac_out_port #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  ac_data,
    input  logic              out_en,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    // Flags and head data derive only from registered state; no input-to-output path.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_MAX);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: a pop frees a slot so a write into a full FIFO is still accepted.
    always_comb begin
        pop        = !empty && out_ready;
        push       = out_en && (!full || pop);
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = (push && !pop) ? count_q + CNT_ONE :
                     (pop && !push) ? count_q - CNT_ONE : count_q;
        overflow_d = (out_en && !push) ? 1'b1 : clr_ovf ? 1'b0 : overflow_q;
    end

    // Control state with immediate reset; stored words are abandoned on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array needs no reset: count gates visibility of its contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ac_data;
    end
endmodule

// File: tb/tb_ac_out_port.sv
// tb_ac_out_port: scoreboard bench for the accumulator output FIFO port
module tb_ac_out_port;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ac_data;
    logic       out_en;
    logic       clr_ovf;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int rx_cnt = 0;
    logic [7:0] exp_q [$];

    ac_out_port #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .ac_data(ac_data), .out_en(out_en),
        .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .full(full), .empty(empty), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit accepted);
        ac_data = d;
        out_en  = 1'b1;
        step();
        out_en  = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !empty; i++) step();
        out_ready = 1'b0;
        chk("drain_empty", empty, 1);
        chk("sb_all_received", exp_q.size(), 0);
    endtask

    // Monitor: inputs change just after posedge, so at negedge they show what the next edge sees.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                chk("rx_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int rx0, sent;
        reset = 1'b1; ac_data = '0; out_en = 0; clr_ovf = 0; out_ready = 0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);

        // Reset mid-cycle with two entries stored
        push(8'h55, 1); push(8'h66, 1);
        chk("pre_rst_count", count, 2);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ovf", overflow, 0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();

        // Single word with hold
        push(8'h01, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h01);
        chk("single_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", out_data, 8'h01);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_empty", empty, 1);
        chk("sb_single", exp_q.size(), 0);

        // Fill, overflow drop, drain
        push(8'h01, 1); push(8'h02, 1); push(8'h04, 1); push(8'h05, 1);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_ovf0", overflow, 0);
        push(8'h0A, 0);
        chk("drop_ovf", overflow, 1);
        chk("drop_count", count, 4);
        drain();
        chk("ovf_sticky", overflow, 1);

        // clr_ovf alone
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Full with simultaneous push and pop
        push(8'h11, 1); push(8'h22, 1); push(8'h33, 1); push(8'h44, 1);
        ac_data = 8'h77; out_en = 1'b1; out_ready = 1'b1;
        step();
        exp_q.push_back(8'h77);
        out_en = 1'b0; out_ready = 1'b0;
        chk("pp_count", count, 4);
        chk("pp_full", full, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", out_data, 8'h22);
        drain();

        // clr_ovf together with a dropped write: set wins
        push(8'hA0, 1); push(8'hA1, 1); push(8'hA2, 1); push(8'hA3, 1);
        clr_ovf = 1'b1;
        push(8'hFF, 0);
        clr_ovf = 1'b0;
        chk("clr_vs_drop", overflow, 1);
        drain();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // Wrap-around stream with toggling ready
        rx0 = rx_cnt;
        sent = 0;
        for (int i = 0; i < 100 && sent < 10; i++) begin
            out_ready = (i % 2 == 0);
            out_en    = !full;
            ac_data   = 8'h10 + 8'(sent);
            step();
            if (out_en) begin
                exp_q.push_back(ac_data);
                sent++;
            end
        end
        out_en = 1'b0;
        chk("stream_sent", sent, 10);
        drain();
        chk("stream_rx", rx_cnt - rx0, 10);
        chk("stream_ovf", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
